// File: rtl/spq_param_if.sv
// Command/result bundle for the spq_param sorted priority queue.
// The master side issues enq/deq with a key/value pair and observes
// the head entry, occupancy and status flags.
interface spq_param_if #(
  parameter int unsigned KEY_W = 16,
  parameter int unsigned VAL_W = 16,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             enq;
  logic             deq;
  logic [KEY_W-1:0] kvi_key;
  logic [VAL_W-1:0] kvi_val;
  logic [KEY_W-1:0] kvo_key;
  logic [VAL_W-1:0] kvo_val;
  logic             full;
  logic             empty;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (
    output enq, deq, kvi_key, kvi_val,
    input  kvo_key, kvo_val, full, empty, busy, count, ovf
  );

  modport slave (
    input  enq, deq, kvi_key, kvi_val,
    output kvo_key, kvo_val, full, empty, busy, count, ovf
  );
endinterface

// File: rtl/spq_param.sv
// spq_param: single-cycle sorted systolic priority queue.
// Cells are kept contiguous from cell 0 (the head) and ordered by key,
// min-first or max-first. Equal keys leave in insertion order. Each cell
// decides its own next value from itself, its neighbours and a per-cell
// "new key belongs at or before me" flag, so no priority encoder is needed.
// Optional feature macro: SPQ_FLUSH_EN adds a synchronous flush input.
module spq_param #(
  parameter int unsigned KEY_W     = 16,
  parameter int unsigned VAL_W     = 16,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MAX_FIRST = 0
) (
  input  logic clk,
  input  logic rst,
`ifdef SPQ_FLUSH_EN
  input  logic flush,
`endif
  spq_param_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_INSERT,
    OP_DROP,
    OP_REMOVE,
    OP_REPLACE,
    OP_FLUSH
  } op_e;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [KEY_W-1:0] key_q [DEPTH];
  logic [KEY_W-1:0] key_d [DEPTH];
  logic [VAL_W-1:0] val_q [DEPTH];
  logic [VAL_W-1:0] val_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;

  op_e              op_c;
  logic [DEPTH-1:0] pos_c;
  logic [DEPTH-1:0] pos_up_c;
  logic [DEPTH-1:0] pos_dn_c;
  logic [DEPTH-1:0] up_valid_c;
  logic [DEPTH-1:0] dn_valid_c;
  logic [KEY_W-1:0] up_key_c [DEPTH];
  logic [KEY_W-1:0] dn_key_c [DEPTH];
  logic [VAL_W-1:0] up_val_c [DEPTH];
  logic [VAL_W-1:0] dn_val_c [DEPTH];

  // True when stored key a is strictly lower priority than incoming key b.
  function automatic logic worse(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    if (MAX_FIRST != 0) return (a < b);
    else                return (a > b);
  endfunction

  // Decode the command for this cycle; flush overrides everything.
  always_comb begin
    op_c = OP_IDLE;
    if (bus.enq && !bus.deq) begin
      op_c = full_q ? OP_DROP : OP_INSERT;
    end else if (bus.deq && !bus.enq) begin
      op_c = empty_q ? OP_IDLE : OP_REMOVE;
    end else if (bus.enq && bus.deq) begin
      op_c = empty_q ? OP_INSERT : OP_REPLACE;
    end
`ifdef SPQ_FLUSH_EN
    if (flush) op_c = OP_FLUSH;
`endif
  end

  // Per-cell placement flag: cell is empty or holds a strictly worse key.
  // Sorted, contiguous storage makes this mask monotone (0..0 1..1).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pos_c[i] = !valid_q[i] || worse(key_q[i], bus.kvi_key);
    end
  end

  // Neighbour views: what each cell would receive on a left or right shift.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      up_valid_c[i] = valid_q[i+1];
      up_key_c[i]   = key_q[i+1];
      up_val_c[i]   = val_q[i+1];
      pos_up_c[i]   = pos_c[i+1];
    end
    up_valid_c[DEPTH-1] = 1'b0;
    up_key_c[DEPTH-1]   = '0;
    up_val_c[DEPTH-1]   = '0;
    pos_up_c[DEPTH-1]   = 1'b1;

    dn_valid_c[0] = 1'b0;
    dn_key_c[0]   = '0;
    dn_val_c[0]   = '0;
    pos_dn_c[0]   = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      dn_valid_c[i] = valid_q[i-1];
      dn_key_c[i]   = key_q[i-1];
      dn_val_c[i]   = val_q[i-1];
      pos_dn_c[i]   = pos_c[i-1];
    end
  end

  // Next-state for cells, occupancy and flags.
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < DEPTH; i++) begin
      key_d[i] = key_q[i];
      val_d[i] = val_q[i];
    end

    case (op_c)
      OP_INSERT: begin
        // Cells at or after the insertion point take their left neighbour;
        // the first such cell takes the new entry.
        for (int i = 0; i < DEPTH; i++) begin
          if (pos_c[i]) begin
            if (pos_dn_c[i]) begin
              valid_d[i] = dn_valid_c[i];
              key_d[i]   = dn_key_c[i];
              val_d[i]   = dn_val_c[i];
            end else begin
              valid_d[i] = 1'b1;
              key_d[i]   = bus.kvi_key;
              val_d[i]   = bus.kvi_val;
            end
          end
        end
        count_d = count_q + CNT_W'(1);
      end

      OP_DROP: begin
        ovf_d = 1'b1;
      end

      OP_REMOVE: begin
        for (int i = 0; i < DEPTH; i++) begin
          valid_d[i] = up_valid_c[i];
          key_d[i]   = up_key_c[i];
          val_d[i]   = up_val_c[i];
        end
        count_d = count_q - CNT_W'(1);
      end

      OP_REPLACE: begin
        // Cells before the insertion point (searched from cell 1) shift
        // left over the departing head; the cell just before it takes kvi.
        for (int i = 0; i < DEPTH; i++) begin
          if (!pos_up_c[i]) begin
            valid_d[i] = up_valid_c[i];
            key_d[i]   = up_key_c[i];
            val_d[i]   = up_val_c[i];
          end else if ((i == 0) || !pos_c[i]) begin
            valid_d[i] = 1'b1;
            key_d[i]   = bus.kvi_key;
            val_d[i]   = bus.kvi_val;
          end
        end
      end

      OP_FLUSH: begin
        valid_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
          key_d[i] = '0;
          val_d[i] = '0;
        end
        count_d = '0;
      end

      default: ;
    endcase

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
        val_q[i] <= '0;
      end
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= key_d[i];
        val_q[i] <= val_d[i];
      end
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.kvo_key = key_q[0];
  assign bus.kvo_val = val_q[0];
  assign bus.count   = count_q;
  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
  assign bus.ovf     = ovf_q;
  assign bus.busy    = 1'b0;

endmodule

// File: tb/tb_spq_param.sv
// Bench for spq_param: a directed vector table on a DEPTH=4 min-first
// queue, hand-written max-first / reset / flush sequences, and random
// traffic on both instances checked against a list-based reference model.
module tb_spq_param;

  logic clk;
  logic rst_n;

  spq_param_if #(.KEY_W(16), .VAL_W(16), .DEPTH(4)) if0 ();
  spq_param_if #(.KEY_W(8),  .VAL_W(16), .DEPTH(8)) if1 ();

`ifdef SPQ_FLUSH_EN
  logic flush0;
  logic flush1;
`endif

  spq_param #(.KEY_W(16), .VAL_W(16), .DEPTH(4), .MAX_FIRST(0)) dut0 (
    .clk  (clk),
    .rst  (rst_n),
`ifdef SPQ_FLUSH_EN
    .flush(flush0),
`endif
    .bus  (if0)
  );

  spq_param #(.KEY_W(8), .VAL_W(16), .DEPTH(8), .MAX_FIRST(1)) dut1 (
    .clk  (clk),
    .rst  (rst_n),
`ifdef SPQ_FLUSH_EN
    .flush(flush1),
`endif
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] key;
    logic [15:0] val;
  } ent_t;

  ent_t m_q[$];
  int   m_depth;
  bit   m_maxf;
  bit   m_ovf;

  // Head = best key; among equals the earliest inserted (lowest index).
  function automatic int m_head();
    int h = 0;
    for (int i = 1; i < m_q.size(); i++) begin
      if (m_maxf ? (m_q[i].key > m_q[h].key) : (m_q[i].key < m_q[h].key)) h = i;
    end
    return h;
  endfunction

  function automatic void m_apply(input logic e, input logic d,
                                  input logic [15:0] k, input logic [15:0] v);
    ent_t n;
    n.key = k;
    n.val = v;
    if (e && !d) begin
      if (m_q.size() == m_depth) m_ovf = 1'b1;
      else m_q.push_back(n);
    end else if (d && !e) begin
      if (m_q.size() != 0) m_q.delete(m_head());
    end else if (e && d) begin
      if (m_q.size() != 0) m_q.delete(m_head());
      m_q.push_back(n);
    end
  endfunction

  function automatic void m_reset(input int depth, input bit maxf);
    m_q.delete();
    m_depth = depth;
    m_maxf  = maxf;
    m_ovf   = 1'b0;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dut(input int which, input string tag, input int ecnt,
                           input logic [15:0] ekey, input logic [15:0] eval,
                           input logic eempty, input logic efull, input logic eovf);
    logic [31:0] a_cnt, a_key, a_val;
    logic a_empty, a_full, a_ovf;
    if (which == 0) begin
      a_cnt = 32'(if0.count); a_key = 32'(if0.kvo_key); a_val = 32'(if0.kvo_val);
      a_empty = if0.empty; a_full = if0.full; a_ovf = if0.ovf;
    end else begin
      a_cnt = 32'(if1.count); a_key = 32'(if1.kvo_key); a_val = 32'(if1.kvo_val);
      a_empty = if1.empty; a_full = if1.full; a_ovf = if1.ovf;
    end
    chk($sformatf("%s.count", tag), a_cnt, 32'(ecnt));
    chk($sformatf("%s.kvo_key", tag), a_key, 32'(ekey));
    chk($sformatf("%s.kvo_val", tag), a_val, 32'(eval));
    chk($sformatf("%s.empty", tag), 32'(a_empty), 32'(eempty));
    chk($sformatf("%s.full", tag), 32'(a_full), 32'(efull));
    chk($sformatf("%s.ovf", tag), 32'(a_ovf), 32'(eovf));
  endtask

  task automatic drive(input int which, input logic e, input logic d,
                       input logic [15:0] k, input logic [15:0] v);
    if0.enq     = (which == 0) && e;
    if0.deq     = (which == 0) && d;
    if0.kvi_key = k;
    if0.kvi_val = v;
    if1.enq     = (which == 1) && e;
    if1.deq     = (which == 1) && d;
    if1.kvi_key = k[7:0];
    if1.kvi_val = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Model-checked step: drive, clock, update model, compare.
  task automatic mstep(input int which, input string tag, input logic e, input logic d,
                       input logic [15:0] k, input logic [15:0] v);
    int h;
    logic [15:0] ek, ev;
    drive(which, e, d, k, v);
    step();
    m_apply(e, d, k, v);
    ek = 16'h0;
    ev = 16'h0;
    if (m_q.size() != 0) begin
      h  = m_head();
      ek = m_q[h].key;
      ev = m_q[h].val;
    end
    check_dut(which, tag, m_q.size(), ek, ev, m_q.size() == 0,
              m_q.size() == m_depth, m_ovf);
  endtask

  task automatic run_random(input int which, input int n);
    logic e, d;
    logic [15:0] k, v;
    for (int i = 0; i < n; i++) begin
      e = ($urandom_range(0, 99) < 60);
      d = ($urandom_range(0, 99) < 45);
      k = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      if (which == 1) k = {8'h00, k[7:0]};
      v = 16'($urandom);
      mstep(which, $sformatf("rnd%0d_%0d", which, i), e, d, k, v);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        enq;
    logic        deq;
    logic [15:0] key;
    logic [15:0] val;
    int          cnt;
    logic [15:0] ekey;
    logic [15:0] eval;
    logic        eempty;
    logic        efull;
    logic        eovf;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic e, input logic d, input logic [15:0] k,
                              input logic [15:0] v, input int c, input logic [15:0] ek,
                              input logic [15:0] ev, input logic em, input logic fu,
                              input logic ov);
    vec_t r;
    r.enq = e; r.deq = d; r.key = k; r.val = v; r.cnt = c;
    r.ekey = ek; r.eval = ev; r.eempty = em; r.efull = fu; r.eovf = ov;
    return r;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
`ifdef SPQ_FLUSH_EN
    flush0 = 1'b0;
    flush1 = 1'b0;
`endif

    // stable ordering, drain to empty
    tbl[0]  = mk(1, 0, 16'd7,  16'h0011, 1, 16'd7,  16'h0011, 0, 0, 0);
    tbl[1]  = mk(1, 0, 16'd3,  16'h000A, 2, 16'd3,  16'h000A, 0, 0, 0);
    tbl[2]  = mk(1, 0, 16'd9,  16'h0022, 3, 16'd3,  16'h000A, 0, 0, 0);
    tbl[3]  = mk(1, 0, 16'd3,  16'h000B, 4, 16'd3,  16'h000A, 0, 1, 0);
    tbl[4]  = mk(0, 1, 16'd0,  16'h0000, 3, 16'd3,  16'h000B, 0, 0, 0);
    tbl[5]  = mk(0, 1, 16'd0,  16'h0000, 2, 16'd7,  16'h0011, 0, 0, 0);
    tbl[6]  = mk(0, 1, 16'd0,  16'h0000, 1, 16'd9,  16'h0022, 0, 0, 0);
    tbl[7]  = mk(0, 1, 16'd0,  16'h0000, 0, 16'd0,  16'h0000, 1, 0, 0);
    // enq+deq on empty acts as insert; deq on empty ignored
    tbl[8]  = mk(1, 1, 16'd10, 16'h0033, 1, 16'd10, 16'h0033, 0, 0, 0);
    tbl[9]  = mk(0, 1, 16'd0,  16'h0000, 0, 16'd0,  16'h0000, 1, 0, 0);
    tbl[10] = mk(0, 1, 16'd0,  16'h0000, 0, 16'd0,  16'h0000, 1, 0, 0);
    // build {1,2,5,8}, drop on full
    tbl[11] = mk(1, 0, 16'd5,  16'h0005, 1, 16'd5,  16'h0005, 0, 0, 0);
    tbl[12] = mk(1, 0, 16'd1,  16'h0001, 2, 16'd1,  16'h0001, 0, 0, 0);
    tbl[13] = mk(1, 0, 16'd8,  16'h0008, 3, 16'd1,  16'h0001, 0, 0, 0);
    tbl[14] = mk(1, 0, 16'd2,  16'h0002, 4, 16'd1,  16'h0001, 0, 1, 0);
    tbl[15] = mk(1, 0, 16'd4,  16'h0004, 4, 16'd1,  16'h0001, 0, 1, 1);
    // replace while full: {2,5,6,8} then {0,5,6,8}
    tbl[16] = mk(1, 1, 16'd6,  16'h0006, 4, 16'd2,  16'h0002, 0, 1, 1);
    tbl[17] = mk(1, 1, 16'd0,  16'h0010, 4, 16'd0,  16'h0010, 0, 1, 1);
    tbl[18] = mk(0, 1, 16'd0,  16'h0000, 3, 16'd5,  16'h0005, 0, 0, 1);
    tbl[19] = mk(0, 1, 16'd0,  16'h0000, 2, 16'd6,  16'h0006, 0, 0, 1);
    tbl[20] = mk(0, 1, 16'd0,  16'h0000, 1, 16'd8,  16'h0008, 0, 0, 1);
    tbl[21] = mk(0, 1, 16'd0,  16'h0000, 0, 16'd0,  16'h0000, 1, 0, 1);

    // reset state
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_dut(0, "reset0", 0, 16'h0, 16'h0, 1, 0, 0);
    check_dut(1, "reset1", 0, 16'h0, 16'h0, 1, 0, 0);
    chk("reset0.busy", 32'(if0.busy), 32'd0);

    for (int i = 0; i < 22; i++) begin
      drive(0, tbl[i].enq, tbl[i].deq, tbl[i].key, tbl[i].val);
      step();
      check_dut(0, $sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].ekey, tbl[i].eval,
                tbl[i].eempty, tbl[i].efull, tbl[i].eovf);
    end
    chk("tbl.busy", 32'(if0.busy), 32'd0);

    // ovf is sticky until reset
    do_reset();
    check_dut(0, "ovf_clr", 0, 16'h0, 16'h0, 1, 0, 0);

    // max-first ordering on the 8-bit instance
    m_reset(8, 1'b1);
    mstep(1, "maxf_a", 1, 0, 16'h10, 16'h0001);
    mstep(1, "maxf_b", 1, 0, 16'hFF, 16'h0002);
    mstep(1, "maxf_c", 1, 0, 16'h80, 16'h0003);
    check_dut(1, "maxf_head", 3, 16'hFF, 16'h0002, 0, 0, 0);
    drive(1, 0, 1, 16'h0, 16'h0);
    step();
    check_dut(1, "maxf_d1", 2, 16'h80, 16'h0003, 0, 0, 0);
    step();
    check_dut(1, "maxf_d2", 1, 16'h10, 16'h0001, 0, 0, 0);
    step();
    check_dut(1, "maxf_d3", 0, 16'h0, 16'h0, 1, 0, 0);

    // asynchronous reset mid-cycle with count=3 and enq held
    do_reset();
    drive(0, 1, 0, 16'd4, 16'h0044); step();
    drive(0, 1, 0, 16'd2, 16'h0022); step();
    drive(0, 1, 0, 16'd6, 16'h0066); step();
    check_dut(0, "pre_rst", 3, 16'd2, 16'h0022, 0, 0, 0);
    drive(0, 1, 0, 16'd1, 16'h0011);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_dut(0, "async_rst", 0, 16'h0, 16'h0, 1, 0, 0);
    @(posedge clk);
    #1;
    check_dut(0, "held_rst", 0, 16'h0, 16'h0, 1, 0, 0);
    drive(0, 0, 0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

`ifdef SPQ_FLUSH_EN
    // flush beats a concurrent enq and leaves ovf alone
    do_reset();
    drive(0, 1, 0, 16'd5, 16'h0005); step();
    drive(0, 1, 0, 16'd1, 16'h0001); step();
    drive(0, 1, 0, 16'd8, 16'h0008); step();
    drive(0, 1, 0, 16'd2, 16'h0002); step();
    drive(0, 1, 0, 16'd4, 16'h0004); step();
    drive(0, 0, 1, 16'd0, 16'h0000); step();
    check_dut(0, "pre_flush", 3, 16'd2, 16'h0002, 0, 0, 1);
    drive(0, 1, 0, 16'd3, 16'h0003);
    flush0 = 1'b1;
    step();
    flush0 = 1'b0;
    check_dut(0, "flush", 0, 16'h0, 16'h0, 1, 0, 1);
    drive(0, 1, 0, 16'd9, 16'h0009); step();
    check_dut(0, "post_flush", 1, 16'd9, 16'h0009, 0, 0, 1);
`endif

    // random traffic against the reference model
    do_reset();
    m_reset(4, 1'b0);
    run_random(0, 400);

    do_reset();
    m_reset(8, 1'b1);
    run_random(1, 400);

    drive(0, 0, 0, 16'h0, 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spq_param.md
Name: spq_param

Overview:
- Next-generation single-cycle priority queue: a sorted systolic shift-register array replacing the fixed-size pipelined heap where low depth and deterministic one-cycle throughput matter.
- Parametrised in key width, value width, depth and ordering mode (min-first or max-first).
- Adds stable ordering among equal keys, an occupancy count and a sticky overflow flag.
- Sits behind the same enq/deq/replace command semantics used by the other priority-queue blocks in the library.

Parameters:
KEY_W, 16, key (priority) width in bits
VAL_W, 16, payload width in bits
DEPTH, 16, number of entries; legal range 2..256
MAX_FIRST, 0, 0 = smallest key at head; 1 = largest key at head

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
enq  in  1  insert request
deq  in  1  remove-head request
kvi_key  in  KEY_W  key to insert
kvi_val  in  VAL_W  payload to insert
kvo_key  out  KEY_W  key of current head (cell 0)
kvo_val  out  VAL_W  payload of current head
full  out  1  count == DEPTH
empty  out  1  count == 0
busy  out  1  constant 0; every accepted op completes in one cycle
count  out  $clog2(DEPTH+1)  number of valid entries
ovf  out  1  sticky: an enq was dropped because the queue was full

Behaviour:
- Storage: DEPTH cells {valid, key, val}. Cell 0 is the head. Valid cells are contiguous from cell 0 and sorted by priority.
- "Better" comparison: a < b when MAX_FIRST=0; a > b when MAX_FIRST=1. Unsigned compare.
- Stability: a new key is placed after all existing entries with an equal key. Equal keys dequeue in insertion order.
- Command decode, evaluated each cycle:
  - enq & !deq & !full -> INSERT.
  - enq & !deq & full -> DROP. State unchanged; ovf <= 1.
  - deq & !enq & !empty -> REMOVE.
  - deq & !enq & empty -> ignored; no flag.
  - enq & deq & !empty -> REPLACE. Head is removed and the new item inserted in the same cycle; count unchanged; legal when full.
  - enq & deq & empty -> treated as INSERT.
- INSERT:
  - Position p = first cell whose entry is invalid or worse than kvi (strictly).
  - Cells >= p shift right by one; cell p <= kvi. Last cell is discarded only when not full, so it is always invalid.
  - count+1.
- REMOVE: all cells shift left by one; cell DEPTH-1 invalidated; count-1.
- REPLACE:
  - p computed against cells 1..DEPTH-1.
  - Cells 1..p-1 shift left; cell p-1 <= kvi. If p==1, cell 0 <= kvi.
  - Cells >= p unchanged.
- Latency: an op sampled at edge N is visible on kvo/count/full/empty immediately after edge N. kvo is driven directly from cell 0 registers, so there is no combinational path from inputs to outputs.
- kvo_key/kvo_val when empty: all zeros, guaranteed because invalid cells are zeroed on shift-in and on reset.
- Reset (asserted anytime, including mid-operation): all cells valid=0, key=0, val=0; count=0; empty=1; full=0; ovf=0; busy=0. Takes effect asynchronously. Deassertion is synchronised externally.
- ovf clears only on reset.
- Widths: count saturates by construction (never exceeds DEPTH). No arithmetic on key/val.

Optional Feature:
- Macro SPQ_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush=1 at an edge invalidates and zeroes all cells and sets count=0.
  - flush has priority over enq/deq in that cycle; the concurrent enq is discarded and does not set ovf.
  - ovf is not cleared by flush.
- Not defined: port absent; no flush logic synthesised.

Test Plan:
1. MAX_FIRST=0, DEPTH=4: reset, enq keys 7,3,9,3(val A then B) -> count=4, full=1, head 3/A; deqs yield 3/A, 3/B, 7, 9, then empty=1, kvo=0.
2. Full queue {1,2,5,8}, enq key 4 alone -> state unchanged, ovf=1 and remains 1 after subsequent deqs until rst low.
3. Full queue {1,2,5,8}, enq key 6 + deq same cycle -> contents {2,5,6,8}, count=4; then replace with key 0 -> {0,5,6,8}.
4. Empty queue, enq key 10 + deq same cycle -> count=1, head=10; deq on empty -> no change, ovf=0.
5. MAX_FIRST=1, KEY_W=8: enq 0x10,0xFF,0x80 -> head 0xFF, then 0x80, then 0x10.
6. Assert rst mid-stream between edges with count=3 -> outputs reset immediately (count=0, empty=1, kvo=0); with SPQ_FLUSH_EN, flush+enq on count=3 -> count=0, ovf unchanged.
